hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use a single clock `clk`; `reset` SHALL be asynchronous and active-high.
REQ-002 The block SHALL have the following ports:
- clk  in  1  pipeline clock
- reset  in  1  async active-high reset
- Rs1D, Rs2D  in  5 each  source registers in Decode
- Rs1E, Rs2E, RdE  in  5 each  sources/dest in Execute
- ResultSrcE  in  2  result select in Execute; 2'b01 = load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- RdM  in  5  dest in Memory
- RegWriteM  in  1  write-enable in Memory
- RdW  in  5  dest in Writeback
- RegWriteW  in  1  write-enable in Writeback
- MemReqM  in  1  data-memory access active in Memory
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1 each  hold the PC / D / E / M pipeline register
- FlushD, FlushE, FlushW  out  1 each  clear the D / E / W pipeline register this edge
- ForwardAE, ForwardBE  out  2 each  operand select: 00 = regfile, 01 = W result, 10 = M ALU result
- MemTimeout  out  1  sticky memory-wait timeout flag
- StallCycles  out  16  saturating count of stalled cycles

Function
REQ-003 ForwardAE SHALL be combinational:
- 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
- else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
- else 00.
- M SHALL win when M and W match simultaneously.
REQ-004 ForwardBE SHALL follow REQ-003 with Rs2E in place of Rs1E.
REQ-005 lwStall SHALL be combinational: ResultSrcE==2'b01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-006 memWait SHALL be combinational: MemReqM & ~MemReadyM.
REQ-007 Output priority SHALL be memWait > PCSrcE > lwStall > none, all combinational in the same cycle.
REQ-008 When memWait is high:
- StallF = StallD = StallE = StallM = 1 and FlushW = 1;
- FlushD = FlushE = 0;
- PCSrcE and lwStall SHALL be ignored.
REQ-009 When memWait is low and PCSrcE is high:
- FlushD = FlushE = 1;
- all stalls = 0 and FlushW = 0;
- a concurrent lwStall SHALL be discarded.
REQ-010 When memWait and PCSrcE are low and lwStall is high:
- StallF = StallD = 1 and FlushE = 1;
- all other stall/flush outputs = 0;
- this gives exactly one bubble per load-use pair.
REQ-011 Otherwise all stall/flush outputs SHALL be 0.
REQ-012 The state machine SHALL have states RUN and MWAIT, registered on posedge clk.
- RUN→MWAIT when memWait.
- MWAIT→RUN when MemReadyM or ~MemReqM.
- MWAIT otherwise holds.
REQ-013 An 8-bit WaitCnt SHALL be:
- cleared in RUN;
- incremented each cycle in MWAIT while memWait;
- saturated at 255.
REQ-014 MemTimeout SHALL set on the clock edge at which WaitCnt==255 and memWait are both high, and SHALL stay set until reset.
REQ-015 MemTimeout SHALL NOT alter the stall outputs; the pipeline SHALL stay frozen until MemReadyM.
REQ-016 StallCycles SHALL increment by 1 on every edge where StallF is high, and SHALL saturate at 16'hFFFF without wrapping.
REQ-017 Forwarding SHALL remain active during stalls, since it is purely a function of its inputs.

Reset
REQ-018 While reset is high:
- state = RUN, WaitCnt = 0, MemTimeout = 0, StallCycles = 0;
- all stall/flush outputs SHALL be forced to 0;
- ForwardAE = ForwardBE = 00.
REQ-019 Reset asserted mid-MWAIT SHALL abandon the wait immediately (asynchronously); after release, the block SHALL start in RUN with counters at 0.
REQ-020 The first rising clk edge after reset deassertion SHALL evaluate normally.

Verification
REQ-021 Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=10; with RdM=0 → ForwardAE=01; with Rs2E=0 and RdW=0 → ForwardBE=00.
REQ-022 Load-use: ResultSrcE=01, RdE=7, Rs2D=7 for one cycle → StallF=StallD=FlushE=1 for that cycle only, and StallCycles increments 0→1.
REQ-023 Branch plus load-use: PCSrcE=1 with a lwStall condition → FlushD=FlushE=1, StallF=0, and StallCycles unchanged.
REQ-024 Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 →
- all four stalls and FlushW high for 3 cycles;
- state returns to RUN;
- StallCycles = 3;
- MemTimeout = 0;
- a PCSrcE asserted during the wait is ignored.
REQ-025 Timeout: MemReqM=1, MemReadyM=0 held for 300 cycles → MemTimeout rises on the edge where WaitCnt==255 and stays high after MemReadyM=1; asserting reset clears it to 0.
REQ-026 Saturation and reset mid-wait:
- preload 65534 stall cycles, then 3 more → StallCycles = 16'hFFFF;
- asserting reset mid-MWAIT → outputs go to the REQ-018 values immediately, without waiting for clk.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush,
// memory-wait freeze with sticky timeout, and a saturating stalled-cycle counter.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemTimeout,
    output logic [15:0] StallCycles
);

    typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lw_stall;
    logic       mem_wait;

    // Memory stage wins over writeback so the youngest producer is forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_M;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_wait = MemReqM && !MemReadyM;

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!reset) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        end
    end

    // Priority: memory wait freezes everything, then branch flush, then load-use bubble.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!reset) begin
            if (mem_wait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            MemTimeout  <= 1'b0;
            StallCycles <= 16'd0;
        end else begin
            if (StallF)
                StallCycles <= sat_inc16(StallCycles);

            if (mem_wait && (wait_cnt == 8'hFF))
                MemTimeout <= 1'b1;

            case (state)
                RUN: begin
                    wait_cnt <= 8'd0;
                    if (mem_wait)
                        state <= MWAIT;
                end
                MWAIT: begin
                    // Leaving the wait (ready or request dropped) restarts the count.
                    if (mem_wait) begin
                        wait_cnt <= sat_inc8(wait_cnt);
                    end else begin
                        wait_cnt <= 8'd0;
                        state    <= RUN;
                    end
                end
                default: begin
                    wait_cnt <= 8'd0;
                    state    <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations checked by immediate assertions.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemTimeout;
    logic [15:0] StallCycles;

    int total;
    int passed;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemTimeout(MemTimeout), .StallCycles(StallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control vector order: StallF StallD StallE StallM FlushD FlushE FlushW
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, exp});
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        passed = 0;

        // Reset with every hazard condition active: outputs must still be quiet.
        reset = 1'b1;
        clear_inputs();
        Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; MemReqM = 1; PCSrcE = 1;
        #1;
        chk_ctl("rst_ctl", 7'b0000000);
        chk("rst_fwdA", ForwardAE, 2'b00);
        chk("rst_fwdB", ForwardBE, 2'b00);
        chk("rst_sc", StallCycles, 0);
        chk("rst_mt", MemTimeout, 0);
        tick(1);
        chk("rst_sc_edge", StallCycles, 0);
        chk("rst_state_edge", dut.state, 0);

        @(negedge clk);
        clear_inputs();
        reset = 1'b0;

        // Forwarding
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1 chk("fwdA_m_wins", ForwardAE, 2'b10);
        RdM = 0;
        #1 chk("fwdA_w", ForwardAE, 2'b01);
        Rs2E = 0; RdW = 0;
        #1 chk("fwdB_x0", ForwardBE, 2'b00);
        chk("fwdA_none", ForwardAE, 2'b00);
        @(negedge clk);
        Rs2E = 9; RdW = 9;
        #1 chk("fwdB_w", ForwardBE, 2'b01);
        RdM = 9;
        #1 chk("fwdB_m", ForwardBE, 2'b10);
        RegWriteM = 0;
        #1 chk("fwdB_m_nowe", ForwardBE, 2'b01);
        chk_ctl("fwd_ctl", 7'b0000000);

        // Load-use: one bubble
        @(negedge clk);
        clear_inputs();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #1 chk_ctl("lu_ctl", 7'b1100010);
        tick(1);
        chk("lu_sc", StallCycles, 1);
        @(negedge clk);
        ResultSrcE = 2'b00;
        #1 chk_ctl("lu_after", 7'b0000000);
        tick(1);
        chk("lu_sc_hold", StallCycles, 1);

        @(negedge clk);
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0;
        #1 chk_ctl("lu_x0", 7'b0000000);
        ResultSrcE = 2'b10; RdE = 7; Rs1D = 7;
        #1 chk_ctl("lu_notload", 7'b0000000);
        ResultSrcE = 2'b01;
        #1 chk_ctl("lu_rs1", 7'b1100010);
        PCSrcE = 1;
        #1 chk_ctl("br_lu", 7'b0000110);
        tick(1);
        chk("br_sc", StallCycles, 1);

        // Memory wait for three cycles with a branch and load-use present
        @(negedge clk);
        reset = 1'b1;
        #1 reset = 1'b0;
        chk("mw_rst_sc", StallCycles, 0);
        MemReqM = 1; MemReadyM = 0;
        #1 chk_ctl("mw_ctl0", 7'b1111001);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk_ctl("mw_ctl", 7'b1111001);
            chk("mw_cnt", dut.wait_cnt, i - 1);
        end
        chk("mw_sc", StallCycles, 3);
        @(negedge clk);
        MemReadyM = 1; PCSrcE = 0; ResultSrcE = 0;
        #1 chk_ctl("mw_ready", 7'b0000000);
        tick(1);
        chk("mw_sc_end", StallCycles, 3);
        chk("mw_state", dut.state, 0);
        chk("mw_cnt_end", dut.wait_cnt, 0);
        chk("mw_mt", MemTimeout, 0);

        // Timeout: 300 waiting cycles
        @(negedge clk);
        clear_inputs();
        MemReqM = 1;
        tick(256);
        chk("to_cnt255", dut.wait_cnt, 255);
        chk("to_not_yet", MemTimeout, 0);
        tick(1);
        chk("to_set", MemTimeout, 1);
        tick(43);
        chk("to_sticky", MemTimeout, 1);
        chk_ctl("to_frozen", 7'b1111001);
        chk("to_sc", StallCycles, 303);
        @(negedge clk);
        MemReadyM = 1;
        #1 chk_ctl("to_ready", 7'b0000000);
        tick(1);
        chk("to_after_ready", MemTimeout, 1);
        chk("to_sc_end", StallCycles, 303);
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        #1 chk("to_rst_mt", MemTimeout, 0);
        chk("to_rst_sc", StallCycles, 0);
        reset = 1'b0;

        // Counter saturation
        @(negedge clk);
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        tick(65534);
        chk("sat_65534", StallCycles, 16'hFFFE);
        tick(3);
        chk("sat_ffff", StallCycles, 16'hFFFF);

        // Asynchronous reset in the middle of a memory wait
        @(negedge clk);
        ResultSrcE = 2'b00;
        MemReqM = 1; MemReadyM = 0;
        Rs1E = 5; RdM = 5; RegWriteM = 1;
        tick(2);
        chk_ctl("rw_ctl", 7'b1111001);
        chk("rw_fwd", ForwardAE, 2'b10);
        chk("rw_state", dut.state, 1);
        reset = 1'b1;
        #1;
        chk_ctl("rw_rst_ctl", 7'b0000000);
        chk("rw_rst_fwd", ForwardAE, 2'b00);
        chk("rw_rst_sc", StallCycles, 0);
        chk("rw_rst_mt", MemTimeout, 0);
        chk("rw_rst_state", dut.state, 0);
        chk("rw_rst_cnt", dut.wait_cnt, 0);

        @(negedge clk);
        clear_inputs();
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        reset = 1'b0;
        tick(1);
        chk("post_rst_edge", StallCycles, 1);
        chk("post_rst_state", dut.state, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
